count_event_monitor: RTL and testbench

- Downstream consumer of the 8-bit up/down counter's count output.
- Samples the count stream and does three things: detects wrap events (overflow 255->0, underflow 0->255), infers count direction, and raises high/low threshold alarms with hysteresis.
- Keeps a saturating wrap-event tally and a sticky step-error flag, both readable by the status/CSR logic.
- Observes the counter's load strobe so that load-induced jumps are not misread as wraps or step errors.

---
 rtl/cnt_mon_pkg.sv | 23 ++
 rtl/cnt_mon_delta.sv | 38 +++
 rtl/count_event_monitor.sv | 144 ++++++++++++++
 tb/tb_count_event_monitor.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cnt_mon_pkg.sv
// Shared types for the count event monitor.
//   mon_state_e : alarm FSM states (PRIME until the first sample, then NORMAL/HIGH/LOW)
//   delta_e     : classification of the step between two consecutive samples
//   CNT_W_DEF   : default count width, matches the 8-bit up/down counter
package cnt_mon_pkg;

  localparam int unsigned CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    PRIME,
    NORMAL,
    HIGH,
    LOW
  } mon_state_e;

  typedef enum logic [1:0] {
    HOLD,
    UP,
    DOWN,
    JUMP
  } delta_e;

endpackage

// File: rtl/cnt_mon_delta.sv
// Combinational step classifier for the count event monitor.
// Ports:
//   prev    in  CNT_W  previous sample
//   count   in  CNT_W  current sample
//   cls     out delta  HOLD / UP / DOWN / JUMP from (count - prev) mod 2**CNT_W
//   wrap_up out 1      UP step out of all-ones (overflow candidate)
//   wrap_dn out 1      DOWN step out of zero (underflow candidate)
module cnt_mon_delta
  import cnt_mon_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic [CNT_W-1:0] prev,
  input  logic [CNT_W-1:0] count,
  output delta_e           cls,
  output logic             wrap_up,
  output logic             wrap_dn
);

  logic [CNT_W-1:0] d;

  always_comb begin
    d       = count - prev;
    cls     = JUMP;
    wrap_up = 1'b0;
    wrap_dn = 1'b0;
    if (d == '0) begin
      cls = HOLD;
    end else if (d == CNT_W'(1)) begin
      cls     = UP;
      wrap_up = (prev == '1);
    end else if (d == '1) begin
      cls     = DOWN;
      wrap_dn = (prev == '0);
    end
  end

endmodule

// File: rtl/count_event_monitor.sv
// Count event monitor: watches the up/down counter's count stream, flags
// overflow/underflow wraps, infers direction, and raises high/low threshold
// alarms with hysteresis. Load-induced jumps are recognised via load_in.
// Optional feature: define CNT_MON_STEP_CHECK_EN to build the sticky
// step_err jump detector; otherwise step_err is tied low.
// Ports:
//   clk, rst (sync, active-low)
//   count, count_vld   sample stream and strobe
//   load_in            counter load control, same cycle the counter sees it
//   thr_hi, thr_lo     alarm thresholds (quasi-static)
//   clr                sync clear of wrap_cnt and step_err
//   ovf_pulse, unf_pulse  one-cycle wrap pulses
//   dir_up             last inferred direction
//   hi_alarm, lo_alarm alarm levels
//   wrap_cnt           saturating wrap tally
//   step_err           sticky unexplained-jump flag
module count_event_monitor
  import cnt_mon_pkg::*;
#(
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned HYST   = 4,
  parameter int unsigned WRAP_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CNT_W-1:0]  count,
  input  logic              count_vld,
  input  logic              load_in,
  input  logic [CNT_W-1:0]  thr_hi,
  input  logic [CNT_W-1:0]  thr_lo,
  input  logic              clr,
  output logic              ovf_pulse,
  output logic              unf_pulse,
  output logic              dir_up,
  output logic              hi_alarm,
  output logic              lo_alarm,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              step_err
);

  logic [CNT_W-1:0] prev;
  logic             ld_pend;
  mon_state_e       state, state_nxt;
  delta_e           cls;
  logic             wrap_up, wrap_dn;
  logic [CNT_W-1:0] hi_rel, lo_rel;
  logic [CNT_W:0]   lo_sum;
  logic             checked;
  logic             ovf_evt, unf_evt;

  cnt_mon_delta #(
    .CNT_W (CNT_W)
  ) u_delta (
    .prev    (prev),
    .count   (count),
    .cls     (cls),
    .wrap_up (wrap_up),
    .wrap_dn (wrap_dn)
  );

  // Release points: saturate rather than wrap so extreme thresholds stay sane.
  always_comb begin
    hi_rel = (thr_hi >= CNT_W'(HYST)) ? (thr_hi - CNT_W'(HYST)) : '0;
    lo_sum = {1'b0, thr_lo} + (CNT_W+1)'(HYST);
    lo_rel = lo_sum[CNT_W] ? '1 : lo_sum[CNT_W-1:0];
  end

  // A sample is delta-checked only once primed and only if the counter did
  // not take a load value on the preceding edge.
  always_comb begin
    checked = count_vld && (state != PRIME) && !ld_pend;
    ovf_evt = checked && wrap_up;
    unf_evt = checked && wrap_dn;
  end

  always_comb begin
    state_nxt = state;
    if (count_vld) begin
      case (state)
        PRIME: begin
          if (count >= thr_hi)      state_nxt = HIGH;
          else if (count <= thr_lo) state_nxt = LOW;
          else                      state_nxt = NORMAL;
        end
        NORMAL: begin
          if (count >= thr_hi)      state_nxt = HIGH;
          else if (count <= thr_lo) state_nxt = LOW;
        end
        HIGH: begin
          if (count < hi_rel) state_nxt = (count <= thr_lo) ? LOW : NORMAL;
        end
        LOW: begin
          if (count > lo_rel) state_nxt = (count >= thr_hi) ? HIGH : NORMAL;
        end
        default: state_nxt = PRIME;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= PRIME;
      prev      <= '0;
      ld_pend   <= 1'b0;
      ovf_pulse <= 1'b0;
      unf_pulse <= 1'b0;
      dir_up    <= 1'b0;
      hi_alarm  <= 1'b0;
      lo_alarm  <= 1'b0;
      wrap_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      hi_alarm  <= (state_nxt == HIGH);
      lo_alarm  <= (state_nxt == LOW);
      ovf_pulse <= ovf_evt;
      unf_pulse <= unf_evt;
      if (count_vld) prev <= count;
      if (load_in)        ld_pend <= 1'b1;
      else if (count_vld) ld_pend <= 1'b0;
      if (checked && cls == UP)        dir_up <= 1'b1;
      else if (checked && cls == DOWN) dir_up <= 1'b0;
      if (clr) begin
        wrap_cnt <= '0;
      end else if ((ovf_evt || unf_evt) && (wrap_cnt != '1)) begin
        wrap_cnt <= wrap_cnt + WRAP_W'(1);
      end
    end
  end

`ifdef CNT_MON_STEP_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      step_err <= 1'b0;
    end else if (clr) begin
      step_err <= 1'b0;
    end else if (checked && cls == JUMP) begin
      step_err <= 1'b1;
    end
  end
`else
  assign step_err = 1'b0;
`endif

endmodule

// File: tb/tb_count_event_monitor.sv
module tb_count_event_monitor;

  localparam int CNT_W  = 8;
  localparam int HYST   = 4;
  localparam int WRAP_W = 4;
  localparam int MOD    = 256;
  localparam int THI    = 200;
  localparam int TLO    = 20;
`ifdef CNT_MON_STEP_CHECK_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic [CNT_W-1:0]  count;
  logic              count_vld;
  logic              load_in;
  logic [CNT_W-1:0]  thr_hi;
  logic [CNT_W-1:0]  thr_lo;
  logic              clr;
  logic              ovf_pulse, unf_pulse, dir_up, hi_alarm, lo_alarm, step_err;
  logic [WRAP_W-1:0] wrap_cnt;

  int checks   = 0;
  int failures = 0;

  count_event_monitor #(
    .CNT_W  (CNT_W),
    .HYST   (HYST),
    .WRAP_W (WRAP_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .count     (count),
    .count_vld (count_vld),
    .load_in   (load_in),
    .thr_hi    (thr_hi),
    .thr_lo    (thr_lo),
    .clr       (clr),
    .ovf_pulse (ovf_pulse),
    .unf_pulse (unf_pulse),
    .dir_up    (dir_up),
    .hi_alarm  (hi_alarm),
    .lo_alarm  (lo_alarm),
    .wrap_cnt  (wrap_cnt),
    .step_err  (step_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: works on integers and named alarm levels.
  // level: 0 = not yet primed, 1 = normal, 2 = high, 3 = low
  bit m_valid = 1'b0;
  int m_prev, m_level, m_wrap, m_c, m_d, hi_rel, lo_rel;
  bit m_ldp, m_jump;
  bit e_ovf, e_unf, e_dir, e_err;

  always @(posedge clk) begin
    if (!rst) begin
      m_valid = 1'b1;
      m_prev = 0; m_level = 0; m_wrap = 0; m_ldp = 1'b0;
      e_ovf = 1'b0; e_unf = 1'b0; e_dir = 1'b0; e_err = 1'b0;
    end else begin
      e_ovf  = 1'b0;
      e_unf  = 1'b0;
      m_jump = 1'b0;
      if (count_vld) begin
        m_c    = int'(count);
        m_d    = (m_c - m_prev + MOD) % MOD;
        hi_rel = (int'(thr_hi) >= HYST) ? int'(thr_hi) - HYST : 0;
        lo_rel = (int'(thr_lo) + HYST > MOD - 1) ? MOD - 1 : int'(thr_lo) + HYST;
        if (m_level == 0) begin
          m_level = (m_c >= int'(thr_hi)) ? 2 : (m_c <= int'(thr_lo)) ? 3 : 1;
        end else begin
          if (!m_ldp) begin
            if (m_d == 1) begin
              e_dir = 1'b1;
              e_ovf = (m_prev == MOD - 1);
            end else if (m_d == MOD - 1) begin
              e_dir = 1'b0;
              e_unf = (m_prev == 0);
            end else if (m_d != 0) begin
              m_jump = 1'b1;
            end
          end
          if (m_level == 1) begin
            if (m_c >= int'(thr_hi))      m_level = 2;
            else if (m_c <= int'(thr_lo)) m_level = 3;
          end else if (m_level == 2) begin
            if (m_c < hi_rel) m_level = (m_c <= int'(thr_lo)) ? 3 : 1;
          end else begin
            if (m_c > lo_rel) m_level = (m_c >= int'(thr_hi)) ? 2 : 1;
          end
        end
        m_prev = m_c;
      end
      if (clr) m_wrap = 0;
      else if ((e_ovf || e_unf) && m_wrap < (1 << WRAP_W) - 1) m_wrap = m_wrap + 1;
      if (clr) e_err = 1'b0;
      else if (m_jump && STEP_EN) e_err = 1'b1;
      if (load_in) m_ldp = 1'b1;
      else if (count_vld) m_ldp = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("ovf_pulse", 32'(ovf_pulse), 32'(e_ovf));
      chk("unf_pulse", 32'(unf_pulse), 32'(e_unf));
      chk("dir_up",    32'(dir_up),    32'(e_dir));
      chk("hi_alarm",  32'(hi_alarm),  32'(m_level == 2));
      chk("lo_alarm",  32'(lo_alarm),  32'(m_level == 3));
      chk("wrap_cnt",  32'(wrap_cnt),  32'(m_wrap));
      chk("step_err",  32'(step_err),  32'(e_err));
    end
  end

  task automatic cyc(input int c, input bit v = 1'b1, input bit ld = 1'b0,
                     input bit cl = 1'b0, input bit r = 1'b1);
    @(negedge clk);
    count     = 8'(c);
    count_vld = v;
    load_in   = ld;
    clr       = cl;
    rst       = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ovf"},  32'(ovf_pulse), 0);
    chk({tag, "_unf"},  32'(unf_pulse), 0);
    chk({tag, "_dir"},  32'(dir_up),    0);
    chk({tag, "_hi"},   32'(hi_alarm),  0);
    chk({tag, "_lo"},   32'(lo_alarm),  0);
    chk({tag, "_wrap"}, 32'(wrap_cnt),  0);
    chk({tag, "_err"},  32'(step_err),  0);
  endtask

  initial begin
    rst = 1'b0; count = '0; count_vld = 1'b0; load_in = 1'b0; clr = 1'b0;
    thr_hi = 8'(THI); thr_lo = 8'(TLO);
    repeat (3) cyc(0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_all_zero("reset");

    // Overflow ramp
    for (int c = 250; c <= 255; c++) cyc(c);
    chk("prime_hi", 32'(hi_alarm), 1);
    cyc(0);
    chk("ovf_seen", 32'(ovf_pulse), 1);
    chk("ovf_wrap", 32'(wrap_cnt), 1);
    chk("ovf_dir",  32'(dir_up), 1);
    chk("ovf_err",  32'(step_err), 0);
    chk("ovf_lo",   32'(lo_alarm), 1);
    cyc(1);
    chk("ovf_once", 32'(ovf_pulse), 0);

    // Underflow
    cyc(2); cyc(1); cyc(0);
    chk("desc_dir", 32'(dir_up), 0);
    cyc(255);
    chk("unf_seen", 32'(unf_pulse), 1);
    chk("unf_wrap", 32'(wrap_cnt), 2);
    chk("unf_lo_rel", 32'(lo_alarm), 0);
    chk("unf_hi",   32'(hi_alarm), 1);

    // High alarm hysteresis
    for (int c = 254; c >= 196; c--) cyc(c);
    chk("hyst_196", 32'(hi_alarm), 1);
    cyc(195);
    chk("hyst_195", 32'(hi_alarm), 0);
    for (int c = 194; c >= 150; c--) cyc(c);
    for (int c = 151; c <= 199; c++) cyc(c);
    chk("rise_199", 32'(hi_alarm), 0);
    cyc(200);
    chk("rise_200", 32'(hi_alarm), 1);
    cyc(197);
    chk("fall_197", 32'(hi_alarm), 1);

    // Load-induced jumps
    for (int c = 198; c <= 254; c++) cyc(c);
    cyc(255, 1'b1, 1'b1);
    cyc(128);
    chk("ld_ovf",  32'(ovf_pulse), 0);
    chk("ld_unf",  32'(unf_pulse), 0);
    chk("ld_err",  32'(step_err), 0);
    chk("ld_wrap", 32'(wrap_cnt), 2);
    cyc(129, 1'b1, 1'b1);
    cyc(255, 1'b1, 1'b1);
    cyc(0);
    chk("ld_wrap_supp", 32'(ovf_pulse), 0);
    chk("ld_wrap_cnt",  32'(wrap_cnt), 2);
    for (int c = 1; c <= 10; c++) cyc(c);
    cyc(90);
    chk("jump_err", 32'(step_err), 32'(STEP_EN));

    // Non-sample cycles and a load on a non-sample cycle
    cyc(91, 1'b0); cyc(91, 1'b0);
    cyc(91);
    cyc(50, 1'b0, 1'b1);
    cyc(200);
    chk("ld_novld_hi", 32'(hi_alarm), 1);

    // clr coinciding with overflow
    cyc(254, 1'b1, 1'b1);
    cyc(255);
    cyc(0, 1'b1, 1'b0, 1'b1);
    chk("clr_ovf",  32'(ovf_pulse), 1);
    chk("clr_wrap", 32'(wrap_cnt), 0);
    chk("clr_err",  32'(step_err), 0);

    // Saturation of the tally
    for (int i = 0; i < 10; i++) begin
      cyc(255);
      cyc(0);
    end
    chk("sat_15", 32'(wrap_cnt), 15);
    cyc(255);
    chk("sat_hold", 32'(wrap_cnt), 15);

    // Reset mid-ramp
    cyc(95);
    for (int c = 96; c <= 100; c++) cyc(c);
    cyc(100, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_all_zero("midrst");
    cyc(160);
    chk("reprime_err", 32'(step_err), 0);
    chk("reprime_ovf", 32'(ovf_pulse), 0);
    chk("reprime_dir", 32'(dir_up), 0);
    cyc(161);
    chk("reprime_up", 32'(dir_up), 1);

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
